// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch direction predictor.
// The branch control unit uses the same opcode-class constant to decode op_f_i.
package bp_pkg;

  // Predictor lifecycle: table initialisation sweep, then normal operation
  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  // Fetch opcode class that marks a conditional branch
  localparam logic [1:0] BP_OP_BRANCH = 2'b11;

  // Weakly-not-taken value for a counter of the given width (0 for 1-bit counters)
  function automatic int bp_wnt_init(input int ctrBits);
    return (1 << (ctrBits - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Next-value logic for a CTR_BITS-wide saturating up/down counter.
// Counts up on taken and down on not-taken, holding at either end without wrapping.
module sat_counter_update #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_ctr,
  input  logic                i_taken,
  output logic [CTR_BITS-1:0] o_ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

  // Move one step toward the resolved direction, clamping at the limits
  always_comb begin
    o_ctr_next = i_ctr;
    if (i_taken && (i_ctr != CTR_MAX)) begin
      o_ctr_next = i_ctr + CTR_BITS'(1);
    end else if (!i_taken && (i_ctr != '0)) begin
      o_ctr_next = i_ctr - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor: a table of saturating counters indexed by
// PC[INDEX_BITS+1:2] XOR the global history register. Prediction is a
// combinational read at fetch; training and history shifting happen at
// execute-stage resolution. After reset the table is swept to weakly-not-taken
// before predictions are enabled.
// Optional macro BRANCH_STATS_EN adds saturating resolved-branch and
// misprediction counters; without it those outputs are tied to zero.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [PC_WIDTH-1:0]   pc_f_i,
  input  logic [1:0]            op_f_i,
  output logic                  pred_taken_f_o,
  output logic [INDEX_BITS-1:0] pht_idx_f_o,
  output logic                  ready_o,
  input  logic                  branch_valid_e_i,
  input  logic [INDEX_BITS-1:0] pht_idx_e_i,
  input  logic                  taken_res_e_i,
  input  logic                  pred_taken_e_i,
  output logic [31:0]           stat_branches_o,
  output logic [31:0]           stat_mispred_o
);

  localparam int                    DEPTH    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   WNT      = CTR_BITS'(bp_wnt_init(CTR_BITS));
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(DEPTH - 1);

  bp_state_e             r_state;
  bp_state_e             w_state_next;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [GHR_BITS-1:0]   r_ghr;
  logic [GHR_BITS-1:0]   w_ghr_next;
  logic [CTR_BITS-1:0]   r_pht [DEPTH];

  logic                  w_run;
  logic                  w_update;
  logic [INDEX_BITS-1:0] w_idx_f;
  logic [CTR_BITS-1:0]   w_ctr_f;
  logic [CTR_BITS-1:0]   w_ctr_e;
  logic [CTR_BITS-1:0]   w_ctr_e_next;

  assign w_run    = (r_state == BP_RUN);
  assign w_update = w_run && branch_valid_e_i;
  assign ready_o  = w_run;

  // Fetch index hashes the word-aligned PC with the zero-extended history
  assign w_idx_f     = pc_f_i[INDEX_BITS+1:2] ^ INDEX_BITS'(r_ghr);
  assign pht_idx_f_o = w_idx_f;

  // Asynchronous read: a same-cycle write is not visible until the next cycle
  assign w_ctr_f        = r_pht[w_idx_f];
  assign pred_taken_f_o = w_run && (op_f_i == BP_OP_BRANCH) && w_ctr_f[CTR_BITS-1];

  assign w_ctr_e = r_pht[pht_idx_e_i];

  sat_counter_update #(
    .CTR_BITS(CTR_BITS)
  ) u_sat_counter_update (
    .i_ctr     (w_ctr_e),
    .i_taken   (taken_res_e_i),
    .o_ctr_next(w_ctr_e_next)
  );

  // Shift the resolved direction into the history; 1-bit history just holds it
  generate
    if (GHR_BITS == 1) begin : gen_ghr_single
      assign w_ghr_next = taken_res_e_i;
    end else begin : gen_ghr_shift
      assign w_ghr_next = {r_ghr[GHR_BITS-2:0], taken_res_e_i};
    end
  endgenerate

  // Low PC bits and any bits above the index do not take part in the hash
  generate
    if (PC_WIDTH > INDEX_BITS + 2) begin : gen_pc_upper
      logic w_unused_pc;
      assign w_unused_pc = ^{pc_f_i[PC_WIDTH-1:INDEX_BITS+2], pc_f_i[1:0]};
    end else begin : gen_pc_exact
      logic w_unused_pc;
      assign w_unused_pc = ^pc_f_i[1:0];
    end
  endgenerate

  // State register; reset always returns to the initialisation sweep
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= BP_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leave the sweep once the last table entry has been written
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BP_INIT: if (r_ptr == LAST_IDX) w_state_next = BP_RUN;
      BP_RUN:  w_state_next = BP_RUN;
      default: w_state_next = BP_INIT;
    endcase
  end

  // Sweep pointer walks every table entry once while initialising
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else if (r_state == BP_INIT) begin
      r_ptr <= r_ptr + INDEX_BITS'(1);
    end
  end

  // History is non-speculative: only resolved branches in RUN shift it
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ghr <= '0;
    end else if (w_update) begin
      r_ghr <= w_ghr_next;
    end
  end

  // Single write port shared by the init sweep and execute-stage training
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (r_state == BP_INIT) begin
        r_pht[r_ptr] <= WNT;
      end else if (branch_valid_e_i) begin
        r_pht[pht_idx_e_i] <= w_ctr_e_next;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  // Saturating counts of resolved branches and of those that were mispredicted
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else if (w_update) begin
      if (r_stat_branches != 32'hFFFF_FFFF) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if ((pred_taken_e_i != taken_res_e_i) && (r_stat_mispred != 32'hFFFF_FFFF)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign stat_branches_o = r_stat_branches;
  assign stat_mispred_o  = r_stat_mispred;
`else
  logic w_unused_pred_e;
  assign w_unused_pred_e = pred_taken_e_i;
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare with default parameters.
// Expected fetch-stage results are pushed to a scoreboard when stimulus is
// driven and popped once the combinational outputs have settled.
// Honours BRANCH_STATS_EN for the statistics outputs.
module tb_branch_predictor_gshare;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] pcF;
  logic [1:0]  opF;
  logic        predTakenF;
  logic [5:0]  phtIdxF;
  logic        ready;
  logic        branchValidE;
  logic [5:0]  phtIdxE;
  logic        takenResE;
  logic        predTakenE;
  logic [31:0] statBranches;
  logic [31:0] statMispred;

  typedef struct packed {
    logic [5:0] idx;
    logic       pred;
  } expT;

  expT         scoreQ[$];
  logic [1:0]  mPht [64];
  logic [5:0]  mGhr;
  int          mBranches;
  int          mMispred;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare dut (
    .clk_i           (clk),
    .reset_n_i       (resetN),
    .pc_f_i          (pcF),
    .op_f_i          (opF),
    .pred_taken_f_o  (predTakenF),
    .pht_idx_f_o     (phtIdxF),
    .ready_o         (ready),
    .branch_valid_e_i(branchValidE),
    .pht_idx_e_i     (phtIdxE),
    .taken_res_e_i   (takenResE),
    .pred_taken_e_i  (predTakenE),
    .stat_branches_o (statBranches),
    .stat_mispred_o  (statMispred)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mPht[i] = 2'd1;
    mGhr      = '0;
    mBranches = 0;
    mMispred  = 0;
  endtask

  // Drive one cycle of stimulus, score the fetch outputs, then advance the model
  task automatic applyStimulus(input logic [31:0] pc, input logic [1:0] op, input logic bv,
                               input logic [5:0] idxE, input logic taken, input logic predE);
    expT e;
    expT want;
    @(negedge clk);
    pcF = pc; opF = op; branchValidE = bv; phtIdxE = idxE; takenResE = taken; predTakenE = predE;
    e.idx  = pc[7:2] ^ mGhr;
    e.pred = (op == 2'b11) ? mPht[e.idx][1] : 1'b0;
    scoreQ.push_back(e);
    #2;
    want = scoreQ.pop_front();
    checkOutput("idxF", 32'(phtIdxF), 32'(want.idx));
    checkOutput("predF", 32'(predTakenF), 32'(want.pred));
    if (bv) begin
      if (taken && mPht[idxE] != 2'd3) mPht[idxE] = mPht[idxE] + 2'd1;
      else if (!taken && mPht[idxE] != 2'd0) mPht[idxE] = mPht[idxE] - 2'd1;
      mGhr = {mGhr[4:0], taken};
      mBranches++;
      if (predE != taken) mMispred++;
    end
  endtask

  task automatic readIdx(input logic [5:0] target);
    logic [5:0] pcBits;
    pcBits = target ^ mGhr;
    applyStimulus({24'd0, pcBits, 2'b00}, 2'b11, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "Br"}, statBranches, STATS ? 32'(mBranches) : 32'd0);
    checkOutput({tag, "Mp"}, statMispred, STATS ? 32'(mMispred) : 32'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetN = 1'b0; branchValidE = 1'b0; opF = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    modelReset();
    checkOutput("rstReady", 32'(ready), 32'd0);
    checkStats("rst");
  endtask

  // Release reset with a branch pending, then time the sweep until ready
  task automatic releaseAndWait();
    int cnt;
    @(negedge clk);
    resetN = 1'b1; opF = 2'b11; pcF = 32'h40;
    branchValidE = 1'b1; phtIdxE = 6'h10; takenResE = 1'b1; predTakenE = 1'b0;
    #2;
    checkOutput("initPred", 32'(predTakenF), 32'd0);
    cnt = 0;
    while (!ready && cnt < 200) begin
      @(posedge clk);
      #1;
      branchValidE = 1'b0;
      cnt++;
    end
    checkOutput("initLen", 32'(cnt), 32'd64);
  endtask

  initial begin
    logic [9:0] takenPat;
    logic [9:0] predPat;
    resetN = 1'b0; pcF = '0; opF = '0; branchValidE = 1'b0;
    phtIdxE = '0; takenResE = 1'b0; predTakenE = 1'b0;
    modelReset();

    // Reset, partial sweep, reset again, full sweep
    applyReset();
    @(negedge clk);
    resetN = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    checkOutput("midInitReady", 32'(ready), 32'd0);
    applyReset();
    releaseAndWait();

    // First prediction, then same-cycle read and taken update at 0x10
    applyStimulus(32'h40, 2'b11, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("idx40", 32'(phtIdxF), 32'h10);
    applyStimulus(32'h40, 2'b11, 1'b1, 6'h10, 1'b1, 1'b0);
    checkOutput("rbwPred", 32'(predTakenF), 32'd0);
    applyStimulus(32'h44, 2'b11, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("afterTrain", 32'(predTakenF), 32'd1);

    // Saturation at both ends of entry 5
    for (int i = 0; i < 4; i++) applyStimulus(32'h0, 2'b00, 1'b1, 6'd5, 1'b1, 1'b0);
    readIdx(6'd5);
    applyStimulus(32'h0, 2'b00, 1'b1, 6'd5, 1'b0, 1'b1);
    readIdx(6'd5);
    for (int i = 0; i < 4; i++) applyStimulus(32'h0, 2'b00, 1'b1, 6'd5, 1'b0, 1'b1);
    readIdx(6'd5);
    applyStimulus(32'h0, 2'b00, 1'b1, 6'd5, 1'b1, 1'b0);
    readIdx(6'd5);
    checkOutput("noWrapLow", 32'(predTakenF), 32'd0);
    applyStimulus(32'h0, 2'b00, 1'b1, 6'd5, 1'b1, 1'b0);
    readIdx(6'd5);
    checkStats("mid");

    // Mid-run reset, then history hashing and statistics over 10 branches
    applyReset();
    releaseAndWait();
    takenPat = 10'b1011001101;
    predPat  = 10'b1001011100;
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h0, 2'b00, 1'b1, 6'(6'h20 + i), takenPat[i], predPat[i]);
    applyStimulus(32'h40, 2'b11, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("ghrHash", 32'(phtIdxF), 32'h15);
    for (int i = 3; i < 10; i++)
      applyStimulus(32'h0, 2'b00, 1'b1, 6'(6'h20 + i), takenPat[i], predPat[i]);
    applyStimulus(32'h0, 2'b00, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("statBr10", statBranches, STATS ? 32'd10 : 32'd0);
    checkOutput("statMp3", statMispred, STATS ? 32'd3 : 32'd0);

    // Random mix of fetches and resolutions against the model
    for (int i = 0; i < 80; i++)
      applyStimulus($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    applyStimulus(32'h0, 2'b00, 1'b0, 6'h00, 1'b0, 1'b0);
    checkStats("rand");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
